// File: rtl/fir_coeff_pkg.sv
// Shared types and constants for the FIR coefficient write path.
package fir_coeff_pkg;

    localparam int COEFF_AW = 6;
    localparam int COEFF_DW = 16;
    localparam int TAP_W    = 6;

    // Tap count presented to the FIR until the first valid commit lands
    localparam logic [TAP_W-1:0] TAP_RESET = 6'd4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_PREAMBLE  = 2'd2,
        ST_DRAIN     = 2'd3
    } schedState_t;

    // Tap count of zero would stall the FIR loop, so it is never staged
    function automatic logic tapCountOk(input logic [TAP_W-1:0] numOfCoeff);
        return (numOfCoeff != {TAP_W{1'b0}});
    endfunction

endpackage

// File: rtl/coeff_wr_fifo.sv
// Small synchronous FIFO holding {address, data} host writes.
// Count, full and empty all come from the registered occupancy so that
// the ready seen by the host never depends on a same-cycle pop.
module coeff_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 22
) (
    input  logic                       iClk12M,
    input  logic                       iRsn,
    input  logic                       iPush,
    input  logic [W-1:0]               iPushData,
    input  logic                       iPop,
    output logic [W-1:0]               oHeadData,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic                       oFull,
    output logic                       oEmpty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wrPtr_r;
    logic [PW-1:0] rdPtr_r;
    logic [CW-1:0] count_r;
    logic          pushOk_s;
    logic          popOk_s;

    assign oFull     = (count_r == CW'(DEPTH));
    assign oEmpty    = (count_r == {CW{1'b0}});
    assign pushOk_s  = iPush & ~oFull;
    assign popOk_s   = iPop & ~oEmpty;
    assign oHeadData = mem_r[rdPtr_r];
    assign oCount    = count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            wrPtr_r <= {PW{1'b0}};
            rdPtr_r <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (pushOk_s) begin
                wrPtr_r <= wrPtr_r + 1'b1;
            end
            if (popOk_s) begin
                rdPtr_r <= rdPtr_r + 1'b1;
            end
            case ({pushOk_s, popOk_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care whenever count says empty
    always_ff @(posedge iClk12M) begin
        if (pushOk_s) begin
            mem_r[wrPtr_r] <= iPushData;
        end
    end

endmodule

// File: rtl/coeff_wr_scheduler.sv
// Buffers host coefficient writes and replays them into the FIR control
// FSM as flag bursts (one preamble cycle, then one addr/data per cycle),
// only in slots where the FIR is idle and no sample strobe is arriving.
module coeff_wr_scheduler
    import fir_coeff_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AW        = COEFF_AW,
    parameter int DW        = COEFF_DW,
    parameter int MAX_BURST = 16
) (
    input  logic             iClk12M,
    input  logic             iRsn,
    input  logic             iEnSample600k,
    input  logic             iFirBusy,
    input  logic             iWrValid,
    input  logic [AW-1:0]    iWrAddr,
    input  logic [DW-1:0]    iWrData,
    output logic             oWrReady,
    input  logic             iCommit,
    input  logic [TAP_W-1:0] iNumOfCoeff,
    output logic             oCoeffUpdateFlag,
    output logic [AW-1:0]    oAddrRam,
    output logic [DW-1:0]    oWrDtRam,
    output logic [TAP_W-1:0] oNumOfCoeff,
    output logic             oSampleMiss,
    output logic             oCfgErr
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    schedState_t      state_r;
    logic [BW-1:0]    burstCnt_r;
    logic [TAP_W-1:0] stagedNum_r;
    logic             stagedValid_r;

    logic [AW+DW-1:0] headData_s;
    logic [CW-1:0]    fifoCount_s;
    logic             fifoFull_s;
    logic             fifoEmpty_s;
    logic             popNow_s;
    logic             preambleEntry_s;
    logic             commitOk_s;

    // A burst keeps popping while entries remain and the burst budget allows
    assign popNow_s = ((state_r == ST_PREAMBLE) || (state_r == ST_DRAIN))
                      && !fifoEmpty_s && (burstCnt_r < BW'(MAX_BURST));

    // A sample strobe in the same cycle takes the slot away from the burst
    assign preambleEntry_s = (state_r == ST_WAIT_SLOT) && !iFirBusy && !iEnSample600k;

    assign commitOk_s = iCommit && tapCountOk(iNumOfCoeff);
    assign oWrReady   = !fifoFull_s;

    coeff_wr_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) uFifo (
        .iClk12M   (iClk12M),
        .iRsn      (iRsn),
        .iPush     (iWrValid),
        .iPushData ({iWrAddr, iWrData}),
        .iPop      (popNow_s),
        .oHeadData (headData_s),
        .oCount    (fifoCount_s),
        .oFull     (fifoFull_s),
        .oEmpty    (fifoEmpty_s)
    );

    // Burst sequencer: owns flag, addr/data and the tap count seen by the FIR
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            state_r          <= ST_IDLE;
            burstCnt_r       <= {BW{1'b0}};
            oCoeffUpdateFlag <= 1'b0;
            oAddrRam         <= {AW{1'b0}};
            oWrDtRam         <= {DW{1'b0}};
            oNumOfCoeff      <= TAP_RESET;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    oCoeffUpdateFlag <= 1'b0;
                    if (!fifoEmpty_s || stagedValid_r) begin
                        state_r <= ST_WAIT_SLOT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_SLOT: begin
                    if (preambleEntry_s) begin
                        state_r          <= ST_PREAMBLE;
                        oCoeffUpdateFlag <= 1'b1;
                        burstCnt_r       <= {BW{1'b0}};
                        // Tap count only moves here, so it is stable while the FIR latches it
                        if (stagedValid_r) begin
                            oNumOfCoeff <= stagedNum_r;
                        end else begin
                            oNumOfCoeff <= oNumOfCoeff;
                        end
                    end else begin
                        state_r          <= ST_WAIT_SLOT;
                        oCoeffUpdateFlag <= 1'b0;
                    end
                end
                ST_PREAMBLE, ST_DRAIN: begin
                    if (popNow_s) begin
                        state_r          <= ST_DRAIN;
                        oCoeffUpdateFlag <= 1'b1;
                        oAddrRam         <= headData_s[AW+DW-1:DW];
                        oWrDtRam         <= headData_s[DW-1:0];
                        burstCnt_r       <= burstCnt_r + 1'b1;
                    end else begin
                        oCoeffUpdateFlag <= 1'b0;
                        if (fifoEmpty_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_WAIT_SLOT;
                        end
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    oCoeffUpdateFlag <= 1'b0;
                end
            endcase
        end
    end

    // Staged tap count; a commit landing with PREAMBLE entry waits for the next burst
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            stagedNum_r   <= TAP_RESET;
            stagedValid_r <= 1'b0;
        end else if (commitOk_s) begin
            stagedNum_r   <= iNumOfCoeff;
            stagedValid_r <= 1'b1;
        end else if (preambleEntry_s) begin
            stagedValid_r <= 1'b0;
        end else begin
            stagedValid_r <= stagedValid_r;
        end
    end

    // Single-cycle status pulses for missed samples and rejected commits
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            oSampleMiss <= 1'b0;
            oCfgErr     <= 1'b0;
        end else begin
            oSampleMiss <= iEnSample600k & oCoeffUpdateFlag;
            oCfgErr     <= iCommit & ~tapCountOk(iNumOfCoeff);
        end
    end

endmodule

// File: tb/tb_coeff_wr_scheduler.sv
// Directed bench for coeff_wr_scheduler. Instance A uses the default burst
// limit, instance B uses MAX_BURST=2; both share the same input stimulus.
module tb_coeff_wr_scheduler;

    logic        iClk12M;
    logic        iRsn;
    logic        iEnSample600k;
    logic        iFirBusy;
    logic        iWrValid;
    logic [5:0]  iWrAddr;
    logic [15:0] iWrData;
    logic        iCommit;
    logic [5:0]  iNumOfCoeff;

    logic        readyA, flagA, missA, errA;
    logic [5:0]  addrA, numA;
    logic [15:0] dataA;
    logic        readyB, flagB, missB, errB;
    logic [5:0]  addrB, numB;
    logic [15:0] dataB;

    int nCmp = 0;
    int nErr = 0;

    coeff_wr_scheduler dutA (
        .iClk12M(iClk12M), .iRsn(iRsn), .iEnSample600k(iEnSample600k), .iFirBusy(iFirBusy),
        .iWrValid(iWrValid), .iWrAddr(iWrAddr), .iWrData(iWrData), .oWrReady(readyA),
        .iCommit(iCommit), .iNumOfCoeff(iNumOfCoeff), .oCoeffUpdateFlag(flagA),
        .oAddrRam(addrA), .oWrDtRam(dataA), .oNumOfCoeff(numA),
        .oSampleMiss(missA), .oCfgErr(errA)
    );

    coeff_wr_scheduler #(.MAX_BURST(2)) dutB (
        .iClk12M(iClk12M), .iRsn(iRsn), .iEnSample600k(iEnSample600k), .iFirBusy(iFirBusy),
        .iWrValid(iWrValid), .iWrAddr(iWrAddr), .iWrData(iWrData), .oWrReady(readyB),
        .iCommit(iCommit), .iNumOfCoeff(iNumOfCoeff), .oCoeffUpdateFlag(flagB),
        .oAddrRam(addrB), .oWrDtRam(dataB), .oNumOfCoeff(numB),
        .oSampleMiss(missB), .oCfgErr(errB)
    );

    initial begin
        iClk12M = 1'b0;
        forever #5 iClk12M = ~iClk12M;
    end

    task automatic tick();
        @(posedge iClk12M);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pushOne(input logic [5:0] a, input logic [15:0] d);
        iWrValid = 1'b1;
        iWrAddr  = a;
        iWrData  = d;
        tick();
        iWrValid = 1'b0;
    endtask

    task automatic test_reset();
        iRsn = 1'b0;
        idle(2);
        nCmp++; if (flagA !== 1'b0) begin nErr++; $display("FAIL rst_flag: got %0b want 0", flagA); end
        nCmp++; if (numA !== 6'd4) begin nErr++; $display("FAIL rst_num: got %0d want 4", numA); end
        iRsn = 1'b1;
        idle(10);
        nCmp++; if (flagA !== 1'b0) begin nErr++; $display("FAIL idle_flag: got %0b want 0", flagA); end
        nCmp++; if (numA !== 6'd4) begin nErr++; $display("FAIL idle_num: got %0d want 4", numA); end
        nCmp++; if (readyA !== 1'b1) begin nErr++; $display("FAIL idle_ready: got %0b want 1", readyA); end
        nCmp++; if ({missA, errA} !== 2'b00) begin nErr++; $display("FAIL idle_pulses: got %b want 00", {missA, errA}); end
        nCmp++; if ({addrA, dataA} !== 22'd0) begin nErr++; $display("FAIL idle_addrdata: got %h want 0", {addrA, dataA}); end
    endtask

    task automatic test_two_writes();
        pushOne(6'h05, 16'h1234);
        pushOne(6'h06, 16'hBEEF);
        nCmp++; if (flagA !== 1'b0) begin nErr++; $display("FAIL two_wait: got %0b want 0", flagA); end
        tick();
        nCmp++; if (flagA !== 1'b1) begin nErr++; $display("FAIL two_pre_flag: got %0b want 1", flagA); end
        tick();
        nCmp++; if ({flagA, addrA, dataA} !== {1'b1, 6'h05, 16'h1234}) begin nErr++; $display("FAIL two_w0: got %h want %h", {flagA, addrA, dataA}, {1'b1, 6'h05, 16'h1234}); end
        tick();
        nCmp++; if ({flagA, addrA, dataA} !== {1'b1, 6'h06, 16'hBEEF}) begin nErr++; $display("FAIL two_w1: got %h want %h", {flagA, addrA, dataA}, {1'b1, 6'h06, 16'hBEEF}); end
        tick();
        nCmp++; if ({flagA, addrA, dataA} !== {1'b0, 6'h06, 16'hBEEF}) begin nErr++; $display("FAIL two_end: got %h want %h", {flagA, addrA, dataA}, {1'b0, 6'h06, 16'hBEEF}); end
        idle(6);
    endtask

    task automatic test_fill();
        logic [5:0]  expA;
        logic [15:0] expD;
        iFirBusy = 1'b1;
        for (int i = 0; i < 4; i++) pushOne(6'h10 + 6'(i), 16'hA000 + 16'(i));
        nCmp++; if (readyA !== 1'b0) begin nErr++; $display("FAIL fill_ready: got %0b want 0", readyA); end
        iWrValid = 1'b1;
        iWrAddr  = 6'h3F;
        iWrData  = 16'h5555;
        idle(2);
        nCmp++; if ({readyA, flagA} !== 2'b00) begin nErr++; $display("FAIL fill_held: got %b want 00", {readyA, flagA}); end
        iWrValid = 1'b0;
        iFirBusy = 1'b0;
        tick();
        nCmp++; if (flagA !== 1'b1) begin nErr++; $display("FAIL fill_pre: got %0b want 1", flagA); end
        for (int i = 0; i < 4; i++) begin
            tick();
            expA = 6'h10 + 6'(i);
            expD = 16'hA000 + 16'(i);
            nCmp++; if ({flagA, addrA, dataA} !== {1'b1, expA, expD}) begin nErr++; $display("FAIL fill_w%0d: got %h want %h", i, {flagA, addrA, dataA}, {1'b1, expA, expD}); end
        end
        tick();
        nCmp++; if ({flagA, readyA} !== 2'b01) begin nErr++; $display("FAIL fill_end: got %b want 01", {flagA, readyA}); end
        idle(10);
    endtask

    task automatic test_max_burst();
        iFirBusy = 1'b1;
        for (int i = 0; i < 4; i++) pushOne(6'h20 + 6'(i), 16'hC000 + 16'(i));
        iFirBusy = 1'b0;
        tick();
        nCmp++; if (flagB !== 1'b1) begin nErr++; $display("FAIL mb_pre0: got %0b want 1", flagB); end
        tick();
        nCmp++; if ({flagB, addrB, dataB} !== {1'b1, 6'h20, 16'hC000}) begin nErr++; $display("FAIL mb_w0: got %h want %h", {flagB, addrB, dataB}, {1'b1, 6'h20, 16'hC000}); end
        tick();
        nCmp++; if ({flagB, addrB, dataB} !== {1'b1, 6'h21, 16'hC001}) begin nErr++; $display("FAIL mb_w1: got %h want %h", {flagB, addrB, dataB}, {1'b1, 6'h21, 16'hC001}); end
        tick();
        nCmp++; if ({flagB, flagA} !== 2'b01) begin nErr++; $display("FAIL mb_gap: got %b want 01", {flagB, flagA}); end
        tick();
        nCmp++; if ({flagB, addrB} !== {1'b1, 6'h21}) begin nErr++; $display("FAIL mb_pre1: got %h want %h", {flagB, addrB}, {1'b1, 6'h21}); end
        tick();
        nCmp++; if ({flagB, addrB, dataB} !== {1'b1, 6'h22, 16'hC002}) begin nErr++; $display("FAIL mb_w2: got %h want %h", {flagB, addrB, dataB}, {1'b1, 6'h22, 16'hC002}); end
        tick();
        nCmp++; if ({flagB, addrB, dataB} !== {1'b1, 6'h23, 16'hC003}) begin nErr++; $display("FAIL mb_w3: got %h want %h", {flagB, addrB, dataB}, {1'b1, 6'h23, 16'hC003}); end
        tick();
        nCmp++; if (flagB !== 1'b0) begin nErr++; $display("FAIL mb_end: got %0b want 0", flagB); end
        idle(6);
    endtask

    task automatic test_commit();
        iCommit     = 1'b1;
        iNumOfCoeff = 6'd0;
        tick();
        iCommit = 1'b0;
        nCmp++; if ({errA, numA} !== {1'b1, 6'd4}) begin nErr++; $display("FAIL cfg_err: got %h want %h", {errA, numA}, {1'b1, 6'd4}); end
        idle(3);
        nCmp++; if ({errA, flagA} !== 2'b00) begin nErr++; $display("FAIL cfg_quiet: got %b want 00", {errA, flagA}); end
        iCommit     = 1'b1;
        iNumOfCoeff = 6'd13;
        tick();
        iCommit = 1'b0;
        nCmp++; if ({errA, numA} !== {1'b0, 6'd4}) begin nErr++; $display("FAIL cmt_staged: got %h want %h", {errA, numA}, {1'b0, 6'd4}); end
        tick();
        nCmp++; if ({flagA, numA} !== {1'b0, 6'd4}) begin nErr++; $display("FAIL cmt_wait: got %h want %h", {flagA, numA}, {1'b0, 6'd4}); end
        tick();
        nCmp++; if ({flagA, numA} !== {1'b1, 6'd13}) begin nErr++; $display("FAIL cmt_pre: got %h want %h", {flagA, numA}, {1'b1, 6'd13}); end
        tick();
        nCmp++; if ({flagA, numA, addrA, dataA} !== {1'b0, 6'd13, 6'h23, 16'hC003}) begin nErr++; $display("FAIL cmt_end: got %h want %h", {flagA, numA, addrA, dataA}, {1'b0, 6'd13, 6'h23, 16'hC003}); end
        idle(4);
    endtask

    task automatic test_miss_and_reset();
        iFirBusy = 1'b1;
        for (int i = 0; i < 4; i++) pushOne(6'h30 + 6'(i), 16'hD000 + 16'(i));
        iFirBusy = 1'b0;
        tick();
        nCmp++; if (flagA !== 1'b1) begin nErr++; $display("FAIL miss_pre: got %0b want 1", flagA); end
        tick();
        nCmp++; if ({missA, addrA} !== {1'b0, 6'h30}) begin nErr++; $display("FAIL miss_d0: got %h want %h", {missA, addrA}, {1'b0, 6'h30}); end
        iEnSample600k = 1'b1;
        tick();
        iEnSample600k = 1'b0;
        nCmp++; if ({missA, flagA, addrA} !== {2'b11, 6'h31}) begin nErr++; $display("FAIL miss_pulse: got %h want %h", {missA, flagA, addrA}, {2'b11, 6'h31}); end
        tick();
        nCmp++; if ({missA, flagA, addrA} !== {2'b01, 6'h32}) begin nErr++; $display("FAIL miss_clear: got %h want %h", {missA, flagA, addrA}, {2'b01, 6'h32}); end
        iRsn = 1'b0;
        tick();
        iRsn = 1'b1;
        nCmp++; if ({flagA, readyA, numA} !== {2'b01, 6'd4}) begin nErr++; $display("FAIL rst_mid: got %h want %h", {flagA, readyA, numA}, {2'b01, 6'd4}); end
        idle(6);
        nCmp++; if ({flagA, addrA, dataA} !== {1'b0, 6'h00, 16'h0000}) begin nErr++; $display("FAIL rst_drop: got %h want 0", {flagA, addrA, dataA}); end
    endtask

    initial begin
        iRsn          = 1'b0;
        iEnSample600k = 1'b0;
        iFirBusy      = 1'b0;
        iWrValid      = 1'b0;
        iWrAddr       = 6'd0;
        iWrData       = 16'd0;
        iCommit       = 1'b0;
        iNumOfCoeff   = 6'd0;
        test_reset();
        test_two_writes();
        test_fill();
        test_max_burst();
        test_commit();
        test_miss_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
